mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter LAT, 1, memory read latency in cycles after the mem_en cycle; legal range is 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rstb  in  1  asynchronous active-low reset.
REQ-006 c_req  in  1  CPU requester wants an access.
REQ-007 c_we  in  1  CPU access is a write.
REQ-008 c_addr  in  ADDR_W  CPU address.
REQ-009 c_wdata  in  DATA_W  CPU write data.
REQ-010 c_done  out  1  one-cycle pulse: CPU access complete.
REQ-011 d_req  in  1  loader/debug requester wants an access.
REQ-012 d_we  in  1  loader access is a write.
REQ-013 d_addr  in  ADDR_W  loader address.
REQ-014 d_wdata  in  DATA_W  loader write data.
REQ-015 d_done  out  1  one-cycle pulse: loader access complete.
REQ-016 rdata  out  DATA_W  read data for the completing access; valid while the matching done is high.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid LAT cycles after the mem_en cycle.

Function
REQ-022 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-023 IDLE: if c_req or d_req is sampled high at an edge, the arbiter SHALL latch the winner's id, we, addr and wdata, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-024 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both requesting, the requester not served last wins.
REQ-025 ACCESS SHALL last exactly one cycle, with mem_en=1 and mem_we/mem_addr/mem_wdata driven from the latched values; the next state is WAIT.
REQ-026 On entering WAIT, a counter SHALL be loaded with LAT; it decrements each WAIT cycle, and the state moves to RESP on the edge where it equals 1.
REQ-027 On that edge, if the access is a read, rdata SHALL capture mem_rdata; on a write, rdata SHALL keep its previous value.
REQ-028 RESP SHALL last one cycle, with only the winner's done=1; the next state is IDLE, and the last-served pointer SHALL be updated to the winner.
REQ-029 req inputs SHALL be ignored in ACCESS, WAIT and RESP; the requester holds req and its operands until its done pulse.
REQ-030 A req dropped mid-transaction SHALL NOT abort the access; done still pulses.
REQ-031 Latency from req sampled to done-high SHALL be LAT+2 cycles; back-to-back throughput is one access per LAT+3 cycles.
REQ-032 mem_en, mem_we, c_done and d_done SHALL be registered and glitch-free; at most one done is high in any cycle.
REQ-033 mem_we SHALL be 0 whenever mem_en=0.

Reset
REQ-034 While rstb=0, the arbiter SHALL immediately force: state=IDLE, pointer=CPU (CPU wins the first tie), counter=0, and all outputs, including rdata, to 0.
REQ-035 A reset asserted mid-transaction SHALL abandon that transaction with no done pulse; the first request after rstb rises is arbitrated fresh.

Structure
REQ-036 State encodings, the port ids (CPU=0, LOADER=1) and the LAT range limits SHALL live in a shared package/header used by control and datapath code.
REQ-037 The design SHALL be a single module with no sub-module; the latency counter is inline.

Verification
REQ-038 Single CPU read, LAT=1, addr=0x10, mem_rdata=0xDEADBEEF -> one mem_en pulse with addr 0x10 and we=0; c_done high 3 cycles after req with rdata=0xDEADBEEF; d_done stays 0.
REQ-039 Both requesters assert together after reset -> CPU served first, then loader; the next tie goes to CPU; grants alternate over 4 transactions.
REQ-040 Loader write, LAT=3, addr=0x20, wdata=0x5 -> mem_en=mem_we=1 for one cycle with addr 0x20 and wdata 0x5; d_done 5 cycles after req; rdata unchanged.
REQ-041 c_req dropped during WAIT -> c_done still pulses once, and the FSM returns to IDLE.
REQ-042 rstb asserted during WAIT -> all outputs are 0 immediately; no done pulse; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester ids, latency limits and the round-robin pick helper.
package mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Requester ids
  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  // Supported memory read latency range and the counter width that covers it
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Round-robin pick: a lone requester always wins; on a tie the requester
  // named by prio (the one not served last) wins.
  function automatic logic pick_winner(input logic cpu_req,
                                       input logic ldr_req,
                                       input logic prio);
    logic win;
    if (cpu_req && ldr_req) begin
      win = prio;
    end else if (ldr_req) begin
      win = PORT_LOADER;
    end else begin
      win = PORT_CPU;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / loader) single-port memory arbiter.
// One access at a time: IDLE -> ACCESS (one mem_en cycle) -> WAIT (LAT
// cycles) -> RESP (one done cycle) -> IDLE. All strobes are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Out-of-range latencies are clamped so the counter never loads 0 or wraps.
  localparam int LAT_EFF = (LAT < LAT_MIN) ? LAT_MIN :
                           (LAT > LAT_MAX) ? LAT_MAX : LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              prio;      // requester that wins the next tie
  logic              win_id;    // latched winner of the current access
  logic              win_we;    // latched direction of the current access

  logic              any_req;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              start;     // IDLE edge that accepts a request
  logic              last_wait; // WAIT edge on which read data is valid

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Arbitration, operand select and next-state decode
  always_comb begin
    any_req   = c_req | d_req;
    grant     = pick_winner(c_req, d_req, prio);
    sel_we    = (grant == PORT_LOADER) ? d_we    : c_we;
    sel_addr  = (grant == PORT_LOADER) ? d_addr  : c_addr;
    sel_wdata = (grant == PORT_LOADER) ? d_wdata : c_wdata;
    start     = (state == ST_IDLE) && any_req;
    last_wait = (state == ST_WAIT) && (cnt == CNT_LAST);
    state_nx  = state;
    unique case (state)
      ST_IDLE:   if (any_req)   state_nx = ST_ACCESS;
      ST_ACCESS:                state_nx = ST_WAIT;
      ST_WAIT:   if (last_wait) state_nx = ST_RESP;
      ST_RESP:                  state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Latch the winner's id and operands when a request is accepted; the
  // memory address/data outputs are these latched registers directly.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      win_id    <= PORT_CPU;
      win_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      win_id    <= grant;
      win_we    <= sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end
  end

  // Registered strobes: mem_en/mem_we for the ACCESS cycle, done for RESP.
  // mem_we is only ever set together with mem_en.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      c_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      mem_en <= start;
      mem_we <= start & sel_we;
      c_done <= last_wait & (win_id == PORT_CPU);
      d_done <= last_wait & (win_id == PORT_LOADER);
    end
  end

  // Latency counter: loaded on entry to WAIT, counts down each WAIT cycle
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (state == ST_ACCESS) begin
      cnt <= CNT_LOAD;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_LAST;
    end
  end

  // Read data capture on the final WAIT edge; writes leave rdata untouched
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdata <= '0;
    end else if (last_wait && !win_we) begin
      rdata <= mem_rdata;
    end
  end

  // Round-robin pointer: after RESP the other requester gets the next tie
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prio <= PORT_CPU;
    end else if (state == ST_RESP) begin
      prio <= (win_id == PORT_CPU) ? PORT_LOADER : PORT_CPU;
    end
  end

endmodule
